// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage (fetch_pc_unit, fetch_skid_buf).
package fetch_pkg;

  localparam int unsigned FETCH_PC_W = 9;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
    logic                  valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,instr} holding slot for the instruction that returns from
// memory while the IF stage is stalled. Clear has priority over load.
module fetch_skid_buf #(
  parameter int unsigned PC_W = fetch_pkg::FETCH_PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     instr_o
);
  import fetch_pkg::*;

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  // Next-state for the slot.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: PC register, synchronous instruction memory interface and IF/ID register.
// Optional misaligned-redirect trap and halt state: `define FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit #(
  parameter int unsigned PC_W      = fetch_pkg::FETCH_PC_W,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] Imem_Addr,
  output logic            Imem_En,
  input  logic [31:0]     Imem_Data,
  output logic [PC_W-1:0] IFID_PC,
  output logic [31:0]     IFID_Instr,
  output logic            IFID_Valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            Misalign_Trap
`endif
);
  import fetch_pkg::*;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  ifid_t           ifid_q, ifid_d;

  logic            skid_load_s, skid_clear_s, skid_valid_s;
  logic [PC_W-1:0] skid_pc_s;
  logic [31:0]     skid_instr_s;
  logic [PC_W-1:0] target_s;
  logic            misalign_s;
  logic            brpc_unused_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_s      = BrPC[PC_W-1:0];
  assign misalign_s    = (BrPC[1:0] != 2'b00);
  assign brpc_unused_s = ^BrPC[31:PC_W];
`else
  assign target_s      = {BrPC[PC_W-1:2], 2'b00};
  assign misalign_s    = 1'b0;
  assign brpc_unused_s = ^{BrPC[31:PC_W], BrPC[1:0]};
`endif

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .pc_i    (fetch_pc_q),
    .instr_i (Imem_Data),
    .valid_o (skid_valid_s),
    .pc_o    (skid_pc_s),
    .instr_o (skid_instr_s)
  );

  // Next-state: redirect beats stall beats normal advance; S_HALT ignores everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = inflight_q;
    ifid_d       = ifid_q;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (PcSel) begin
      pc_d         = target_s;
      inflight_d   = 1'b0;
      skid_clear_s = 1'b1;
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      state_d      = misalign_s ? S_HALT : S_BOOT;
    end else if (Stall) begin
      if (state_q == S_RUN) begin
        // Data for the in-flight fetch returns now; park it until the stall ends.
        skid_load_s = inflight_q;
        inflight_d  = 1'b0;
        state_d     = S_STALL;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          ifid_d.pc    = fetch_pc_q;
          ifid_d.instr = inflight_q ? Imem_Data : NOP_INSTR;
          ifid_d.valid = inflight_q;
        end
        S_STALL: begin
          skid_clear_s = 1'b1;
          if (skid_valid_s) begin
            ifid_d.pc    = skid_pc_s;
            ifid_d.instr = skid_instr_s;
            ifid_d.valid = 1'b1;
          end else begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
          end
        end
        default: begin
          ifid_d.instr = NOP_INSTR;
          ifid_d.valid = 1'b0;
        end
      endcase
      fetch_pc_d = pc_q;
      inflight_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
      state_d    = S_RUN;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_q       <= '0;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      ifid_q     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      ifid_q     <= ifid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trap_q <= 1'b0;
    end else if ((state_q != S_HALT) && PcSel && misalign_s) begin
      trap_q <= 1'b1;
    end else begin
      trap_q <= trap_q;
    end
  end

  assign Misalign_Trap = trap_q;
`endif

  assign Imem_Addr  = pc_q;
  assign Imem_En    = reset && !Stall && !PcSel && (state_q != S_HALT);
  assign IFID_PC    = ifid_q.pc;
  assign IFID_Instr = ifid_q.instr;
  assign IFID_Valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a
// queue-based model of issued-but-not-yet-delivered fetch addresses.
module tb_fetch_pc_unit;

  localparam int          PC_MOD = 512;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = 32'h0;
  logic [8:0]  Imem_Addr;
  logic        Imem_En;
  logic [31:0] Imem_Data = 32'h0;
  logic [8:0]  IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        Misalign_Trap;
`endif

  fetch_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Imem_Addr  (Imem_Addr),
    .Imem_En    (Imem_En),
    .Imem_Data  (Imem_Data),
    .IFID_PC    (IFID_PC),
    .IFID_Instr (IFID_Instr),
    .IFID_Valid (IFID_Valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .Misalign_Trap (Misalign_Trap)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {a, 23'h0} ^ 32'h1234_5677 ^ {23'h0, a};
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (Imem_En === 1'b1) Imem_Data <= mem_word(Imem_Addr);
  end

  int n_vec = 0;
  int n_err = 0;

  // Model: next PC to issue, queue of issued addresses not yet in IF/ID, IF/ID content.
  int m_pc = 0;
  int m_q[$];
  int m_ipc = 0;
  bit m_v = 1'b0;
  bit m_halt = 1'b0;
  bit m_trap = 1'b0;

  task automatic model_step();
    if (!reset) begin
      m_pc = 0; m_q.delete(); m_v = 1'b0; m_ipc = 0; m_halt = 1'b0; m_trap = 1'b0;
    end else if (m_halt) begin
      m_v = 1'b0;
    end else if (PcSel) begin
      m_q.delete();
      m_v  = 1'b0;
      m_pc = int'(BrPC % PC_MOD);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (BrPC[1:0] != 2'b00) begin m_halt = 1'b1; m_trap = 1'b1; end
`else
      m_pc = m_pc - (m_pc % 4);
`endif
    end else if (!Stall) begin
      if (m_q.size() > 0) begin m_ipc = m_q.pop_front(); m_v = 1'b1; end
      else m_v = 1'b0;
      m_q.push_back(m_pc);
      m_pc = (m_pc + 4) % PC_MOD;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic p, input logic [31:0] b);
    reset = r; Stall = s; PcSel = p; BrPC = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", IFID_Valid); end
    n_vec++; if (IFID_PC !== 9'h000) begin n_err++; $display("FAIL reset_pc: got %h want 000", IFID_PC); end
    n_vec++; if (IFID_Instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", IFID_Instr, NOP); end
    n_vec++; if (Imem_Addr !== 9'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", Imem_Addr); end
    n_vec++; if (Imem_En !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", Imem_En); end
    reset = 1'b1; #1;
    n_vec++; if (Imem_En !== 1'b1) begin n_err++; $display("FAIL boot_en: got %b want 1", Imem_En); end
  endtask

  task automatic test_boot();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL boot_edge1: valid got %b want 0", IFID_Valid); end
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (IFID_Valid !== 1'b1 || IFID_PC !== 9'(4 * k) || IFID_Instr !== mem_word(9'(4 * k))) begin
        n_err++; $display("FAIL boot_edge%0d: got v=%b pc=%h ins=%h want pc=%h", k + 2, IFID_Valid, IFID_PC, IFID_Instr, 4 * k);
      end
    end
  endtask

  task automatic test_stall();
    Stall = 1'b1; #1;
    n_vec++; if (Imem_En !== 1'b0) begin n_err++; $display("FAIL stall_en: got %b want 0", Imem_En); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      n_vec++;
      if (IFID_Valid !== 1'b1 || IFID_PC !== 9'h004) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%h want pc=004", k, IFID_Valid, IFID_PC);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (IFID_Valid !== 1'b1 || IFID_PC !== 9'(8 + 4 * k) || IFID_Instr !== mem_word(9'(8 + 4 * k))) begin
        n_err++; $display("FAIL stall_release%0d: got v=%b pc=%h ins=%h want pc=%h", k, IFID_Valid, IFID_PC, IFID_Instr, 8 + 4 * k);
      end
    end
  endtask

  task automatic test_redirect();
    tick(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    n_vec++; if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP) begin n_err++; $display("FAIL redir_flush: got v=%b ins=%h want 0/%h", IFID_Valid, IFID_Instr, NOP); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL redir_boot: got v=%b want 0", IFID_Valid); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b1 || IFID_PC !== 9'h040 || IFID_Instr !== mem_word(9'h040)) begin
      n_err++; $display("FAIL redir_target: got v=%b pc=%h want 1/040", IFID_Valid, IFID_PC);
    end
  endtask

  task automatic test_redirect_over_stall();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    n_vec++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL rs_flush: got v=%b want 0", IFID_Valid); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (IFID_Valid !== 1'b1 || IFID_PC !== 9'(128 + 4 * k)) begin
        n_err++; $display("FAIL rs_target%0d: got v=%b pc=%h want pc=%h", k, IFID_Valid, IFID_PC, 128 + 4 * k);
      end
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 1'b1, 32'h0000_01F8);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (Imem_Addr !== 9'h000) begin n_err++; $display("FAIL wrap_addr: got %h want 000", Imem_Addr); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_PC !== 9'h1FC || IFID_Valid !== 1'b1) begin n_err++; $display("FAIL wrap_1fc: got v=%b pc=%h want 1/1fc", IFID_Valid, IFID_PC); end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_PC !== 9'h000 || IFID_Instr !== mem_word(9'h000)) begin n_err++; $display("FAIL wrap_000: got pc=%h ins=%h want 000", IFID_PC, IFID_Instr); end
  endtask

  task automatic test_reset_mid_stall();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (IFID_Valid !== 1'b0 || IFID_PC !== 9'h000 || IFID_Instr !== NOP || Imem_Addr !== 9'h000) begin
      n_err++; $display("FAIL midreset: got v=%b pc=%h ins=%h addr=%h want 0/000/%h/000", IFID_Valid, IFID_PC, IFID_Instr, Imem_Addr, NOP);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b1 || IFID_PC !== 9'h000) begin n_err++; $display("FAIL midreset_first: got v=%b pc=%h want 1/000", IFID_Valid, IFID_PC); end
  endtask

  task automatic test_misalign();
    tick(1'b1, 1'b0, 1'b1, 32'h0000_0042);
`ifdef FETCH_MISALIGN_TRAP_EN
    n_vec++; if (Misalign_Trap !== 1'b1) begin n_err++; $display("FAIL trap_set: got %b want 1", Misalign_Trap); end
    for (int k = 0; k < 4; k++) begin
      reset = 1'b1; Stall = 1'b0; PcSel = k[0]; BrPC = 32'h0000_0100; #1;
      n_vec++; if (Imem_En !== 1'b0) begin n_err++; $display("FAIL halt_en%0d: got %b want 0", k, Imem_En); end
      tick(1'b1, 1'b0, k[0], 32'h0000_0100);
      n_vec++; if (IFID_Valid !== 1'b0 || Misalign_Trap !== 1'b1) begin n_err++; $display("FAIL halt_hold%0d: got v=%b trap=%b want 0/1", k, IFID_Valid, Misalign_Trap); end
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (Misalign_Trap !== 1'b0) begin n_err++; $display("FAIL trap_clear: got %b want 0", Misalign_Trap); end
`else
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (IFID_Valid !== 1'b1 || IFID_PC !== 9'h040) begin n_err++; $display("FAIL misalign_force: got v=%b pc=%h want 1/040", IFID_Valid, IFID_PC); end
`endif
  endtask

  task automatic test_random();
    logic r, s, p, exp_en;
    logic [31:0] b;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 30);
      p = ($urandom_range(0, 99) < 8);
      b = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 9) != 0) b[1:0] = 2'b00;
      if (m_halt && $urandom_range(0, 9) == 0) r = 1'b0;
`endif
      reset = r; Stall = s; PcSel = p; BrPC = b; #1;
      exp_en = r && !s && !p && !m_halt;
      n_vec++;
      if (Imem_En !== exp_en || Imem_Addr !== 9'(m_pc)) begin
        n_err++; $display("FAIL rand_fetch[%0d]: got en=%b addr=%h want en=%b addr=%h", i, Imem_En, Imem_Addr, exp_en, 9'(m_pc));
      end
      tick(r, s, p, b);
      n_vec++;
      if (IFID_Valid !== m_v || (m_v && (IFID_PC !== 9'(m_ipc) || IFID_Instr !== mem_word(9'(m_ipc)))) || (!m_v && IFID_Instr !== NOP)) begin
        n_err++; $display("FAIL rand_ifid[%0d]: got v=%b pc=%h ins=%h want v=%b pc=%h", i, IFID_Valid, IFID_PC, IFID_Instr, m_v, 9'(m_ipc));
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_vec++;
      if (Misalign_Trap !== m_trap) begin n_err++; $display("FAIL rand_trap[%0d]: got %b want %b", i, Misalign_Trap, m_trap); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_wrap();
    test_reset_mid_stall();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
